// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: AXI4-Lite-style AR/R read channel to instruction
// memory plus the valid/ready instruction handoff to the decoder.
interface ifu_fetch_if #(
  parameter int unsigned WIDTH = 32
);
  logic             arvalid;
  logic             arready;
  logic [WIDTH-1:0] araddr;
  logic             rvalid;
  logic             rready;
  logic [31:0]      rdata;
  logic [1:0]       rresp;
  logic             inst_valid;
  logic             inst_ready;
  logic [31:0]      inst;
  logic [WIDTH-1:0] inst_pc;
  logic             inst_fault;

  modport master (
    output arvalid, araddr, rready, inst_valid, inst, inst_pc, inst_fault,
    input  arready, rvalid, rdata, rresp, inst_ready
  );

  modport slave (
    input  arvalid, araddr, rready, inst_valid, inst, inst_pc, inst_fault,
    output arready, rvalid, rdata, rresp, inst_ready
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one AR/R read per PC value, handoff to the decoder,
// then wait for pc_update before fetching again.
module ifu_fetch #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc,
  input  logic             pc_update,
  ifu_fetch_if.master      bus,
  output logic             busy
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, AR, R, OUT} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [31:0]     inst_q;
  logic [WIDTH-1:0] inst_pc_q;
  logic            fault_q;
  logic            misaligned;
  logic            timeout_hit;

  assign misaligned  = (pc[1:0] != 2'b00);
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= AR;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (pc_update) state_next = AR;
      AR: begin
        if (misaligned)       state_next = OUT;
        else if (bus.arready) state_next = R;
      end
      R: if (bus.rvalid || timeout_hit) state_next = OUT;
      OUT: if (bus.inst_ready) state_next = pc_update ? AR : IDLE;
      default: state_next = AR;
    endcase
  end

  // Valids are gated by rst so the state left over from before a reset
  // cannot present a request or an instruction during the reset cycle.
  always_comb begin
    bus.arvalid    = !rst && (state == AR) && !misaligned;
    bus.araddr     = (state == AR) ? pc : '0;
    bus.rready     = !rst && (state == R);
    bus.inst_valid = !rst && (state == OUT);
    busy           = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q    <= '0;
      inst_pc_q <= '0;
      fault_q   <= 1'b0;
      cnt       <= '0;
    end else begin
      unique case (state)
        AR: begin
          if (misaligned) begin
            inst_pc_q <= pc;
            inst_q    <= '0;
            fault_q   <= 1'b1;
          end else if (bus.arready) begin
            inst_pc_q <= pc;
            cnt       <= '0;
          end
        end
        R: begin
          if (bus.rvalid) begin
            inst_q  <= bus.rdata;
            fault_q <= (bus.rresp != 2'b00);
          end else if (timeout_hit) begin
            inst_q  <= '0;
            fault_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_fault = fault_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed cycle-vector bench for ifu_fetch with TIMEOUT=8.
module tb_ifu_fetch;

  localparam logic [31:0] P  = 32'h8000_0000;
  localparam logic [31:0] P4 = 32'h8000_0004;
  localparam logic [31:0] P8 = 32'h8000_0008;
  localparam logic [31:0] PC = 32'h8000_000C;
  localparam logic [31:0] M  = 32'h8000_0002;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_update;
  logic        busy;

  ifu_fetch_if #(.WIDTH(32)) bus ();

  ifu_fetch #(.WIDTH(32), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .pc_update (pc_update),
    .bus       (bus),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        upd, ar, rv;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        ir;
    logic        e_av;
    logic [31:0] e_addr;
    logic        e_rr, e_iv;
    logic [31:0] e_inst, e_ipc;
    logic        e_f, e_busy;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;
  int   ar_hs  = 0;
  int   r_hs   = 0;

  task automatic add(input logic r, input logic [31:0] p, input logic u, input logic a,
                     input logic v, input logic [31:0] d, input logic [1:0] rs, input logic i,
                     input logic eav, input logic [31:0] ead, input logic err, input logic eiv,
                     input logic [31:0] ein, input logic [31:0] eip, input logic ef,
                     input logic eb);
    vec_t t;
    t = '{r, p, u, a, v, d, rs, i, eav, ead, err, eiv, ein, eip, ef, eb};
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row%0d %s: got %h expected %h", row, name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (bus.arvalid && bus.arready) ar_hs++;
    if (bus.rvalid && bus.rready) r_hs++;
    // pc_update while a read is in flight (AR or R) is a protocol violation
    if (pc_update && !rst) begin
      checks++;
      if (busy && !bus.inst_valid) begin
        errors++;
        $display("FAIL pc_update_in_flight: got 1 expected 0");
      end
    end
  end

  initial begin
    int cycles;

    //   rst pc  upd ar rv rdata          rr  ir | av addr rr iv inst           ipc f  busy
    add(1, P,  0, 0, 0, 32'h0,        2'd0, 0,  0, P,  0, 0, 32'h0,        32'h0, 0, 1);
    add(0, P,  0, 1, 0, 32'h0,        2'd0, 0,  1, P,  0, 0, 32'h0,        32'h0, 0, 1);
    add(0, P,  0, 0, 1, 32'h00000413, 2'd0, 0,  0, 0,  1, 0, 32'h0,        P,     0, 1);
    add(0, P,  0, 0, 0, 32'h0,        2'd0, 0,  0, 0,  0, 1, 32'h00000413, P,     0, 1);
    add(0, P,  0, 0, 0, 32'h0,        2'd0, 1,  0, 0,  0, 1, 32'h00000413, P,     0, 1);
    for (int k = 0; k < 2; k++)
      add(0, P, 0, 0, 0, 32'h0,       2'd0, 0,  0, 0,  0, 0, 32'h00000413, P,     0, 0);
    add(0, P,  1, 0, 0, 32'h0,        2'd0, 0,  0, 0,  0, 0, 32'h00000413, P,     0, 0);
    for (int k = 0; k < 3; k++)
      add(0, P4, 0, 0, 0, 32'h0,      2'd0, 0,  1, P4, 0, 0, 32'h00000413, P,     0, 1);
    add(0, P4, 0, 1, 0, 32'h0,        2'd0, 0,  1, P4, 0, 0, 32'h00000413, P,     0, 1);
    for (int k = 0; k < 4; k++)
      add(0, P4, 0, 0, 0, 32'h0,      2'd0, 0,  0, 0,  1, 0, 32'h00000413, P4,    0, 1);
    add(0, P4, 0, 0, 1, 32'h00A00093, 2'd0, 0,  0, 0,  1, 0, 32'h00000413, P4,    0, 1);
    for (int k = 0; k < 5; k++)
      add(0, P4, 0, 0, 0, 32'h0,      2'd0, 0,  0, 0,  0, 1, 32'h00A00093, P4,    0, 1);
    add(0, P4, 1, 0, 0, 32'h0,        2'd0, 1,  0, 0,  0, 1, 32'h00A00093, P4,    0, 1);
    add(0, P8, 0, 1, 0, 32'h0,        2'd0, 0,  1, P8, 0, 0, 32'h00A00093, P4,    0, 1);
    for (int k = 0; k < 8; k++)
      add(0, P8, 0, 0, 0, 32'h0,      2'd0, 0,  0, 0,  1, 0, 32'h00A00093, P8,    0, 1);
    add(0, P8, 0, 0, 1, 32'h12345678, 2'd0, 0,  0, 0,  0, 1, 32'h0,        P8,    1, 1);
    add(0, P8, 0, 0, 0, 32'h0,        2'd0, 1,  0, 0,  0, 1, 32'h0,        P8,    1, 1);
    add(0, P8, 1, 0, 0, 32'h0,        2'd0, 0,  0, 0,  0, 0, 32'h0,        P8,    1, 0);
    add(0, PC, 0, 1, 0, 32'h0,        2'd0, 0,  1, PC, 0, 0, 32'h0,        P8,    1, 1);
    add(0, PC, 0, 0, 1, 32'hDEADBEEF, 2'd2, 0,  0, 0,  1, 0, 32'h0,        PC,    1, 1);
    add(0, PC, 0, 0, 0, 32'h0,        2'd0, 1,  0, 0,  0, 1, 32'hDEADBEEF, PC,    1, 1);
    add(0, PC, 1, 0, 0, 32'h0,        2'd0, 0,  0, 0,  0, 0, 32'hDEADBEEF, PC,    1, 0);
    add(0, M,  0, 1, 0, 32'h0,        2'd0, 0,  0, M,  0, 0, 32'hDEADBEEF, PC,    1, 1);
    add(0, M,  0, 0, 0, 32'h0,        2'd0, 1,  0, 0,  0, 1, 32'h0,        M,     1, 1);
    add(0, M,  1, 0, 0, 32'h0,        2'd0, 0,  0, 0,  0, 0, 32'h0,        M,     1, 0);
    add(0, P,  0, 1, 0, 32'h0,        2'd0, 0,  1, P,  0, 0, 32'h0,        M,     1, 1);
    add(0, P,  0, 0, 1, 32'h00000013, 2'd0, 0,  0, 0,  1, 0, 32'h0,        P,     1, 1);
    add(0, P,  0, 0, 0, 32'h0,        2'd0, 0,  0, 0,  0, 1, 32'h00000013, P,     0, 1);
    add(0, P,  1, 0, 0, 32'h0,        2'd0, 1,  0, 0,  0, 1, 32'h00000013, P,     0, 1);
    add(0, P,  0, 1, 0, 32'h0,        2'd0, 0,  1, P,  0, 0, 32'h00000013, P,     0, 1);
    add(0, P,  0, 0, 0, 32'h0,        2'd0, 0,  0, 0,  1, 0, 32'h00000013, P,     0, 1);
    add(1, P,  0, 0, 0, 32'h0,        2'd0, 0,  0, 0,  0, 0, 32'h00000013, P,     0, 1);
    add(0, P,  0, 0, 0, 32'h0,        2'd0, 0,  1, P,  0, 0, 32'h0,        32'h0, 0, 1);
    add(0, P,  0, 1, 0, 32'h0,        2'd0, 0,  1, P,  0, 0, 32'h0,        32'h0, 0, 1);
    add(0, P,  0, 0, 0, 32'h0,        2'd0, 0,  0, 0,  1, 0, 32'h0,        P,     0, 1);
    add(0, P,  0, 0, 1, 32'h00000093, 2'd0, 0,  0, 0,  1, 0, 32'h0,        P,     0, 1);
    add(0, P,  0, 0, 0, 32'h0,        2'd0, 1,  0, 0,  0, 1, 32'h00000093, P,     0, 1);
    add(0, P,  0, 0, 0, 32'h0,        2'd0, 0,  0, 0,  0, 0, 32'h00000093, P,     0, 0);

    rst = 1'b1; pc = P; pc_update = 1'b0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0;
    bus.inst_ready = 1'b0;
    #1;
    chk("reset_arvalid", -1, {31'b0, bus.arvalid}, 32'h0);
    chk("reset_rready", -1, {31'b0, bus.rready}, 32'h0);
    chk("reset_inst_valid", -1, {31'b0, bus.inst_valid}, 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; pc = vecs[i].pc; pc_update = vecs[i].upd;
      bus.arready = vecs[i].ar; bus.rvalid = vecs[i].rv;
      bus.rdata = vecs[i].rdata; bus.rresp = vecs[i].rresp;
      bus.inst_ready = vecs[i].ir;
      #1;
      chk("arvalid", i, {31'b0, bus.arvalid}, {31'b0, vecs[i].e_av});
      chk("araddr", i, bus.araddr, vecs[i].e_addr);
      chk("rready", i, {31'b0, bus.rready}, {31'b0, vecs[i].e_rr});
      chk("inst_valid", i, {31'b0, bus.inst_valid}, {31'b0, vecs[i].e_iv});
      chk("inst", i, bus.inst, vecs[i].e_inst);
      chk("inst_pc", i, bus.inst_pc, vecs[i].e_ipc);
      chk("inst_fault", i, {31'b0, bus.inst_fault}, {31'b0, vecs[i].e_f});
      chk("busy", i, {31'b0, busy}, {31'b0, vecs[i].e_busy});
    end

    // Zero-wait memory: inst_valid should rise two cycles after entering AR.
    @(negedge clk);
    pc = 32'h8000_0010; pc_update = 1'b1; bus.arready = 1'b1;
    bus.rvalid = 1'b1; bus.rdata = 32'h0000_0011; bus.rresp = 2'd0; bus.inst_ready = 1'b0;
    @(negedge clk);
    pc_update = 1'b0;
    cycles = 0;
    #1;
    while (!bus.inst_valid && cycles < 20) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    chk("latency_cycles", -2, cycles, 32'd2);
    chk("latency_inst", -2, bus.inst, 32'h0000_0011);
    chk("latency_inst_pc", -2, bus.inst_pc, 32'h8000_0010);
    bus.inst_ready = 1'b1; bus.rvalid = 1'b0; bus.arready = 1'b0;
    @(negedge clk);
    bus.inst_ready = 1'b0;
    #1;
    chk("final_busy", -2, {31'b0, busy}, 32'h0);
    chk("ar_handshakes", -2, ar_hs, 32'd8);
    chk("r_handshakes", -2, r_hs, 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
